f_pc_ctrl: RTL and testbench
============================

Name: f_pc_ctrl

Overview:
- Parametrised next-generation fetch-PC controller for the 5-stage MIPS pipeline.
- Owns the F-stage PC register and merges D-stage branch/jump/jr redirects (delay-slot semantics) with CP0 exception entry and eret return.
- Adds stall freeze, instruction-address-error (AdEL) detection, F-stage squash after eret, and a taken-redirect performance counter.

Parameters:
- WIDTH, 32, address/data width; min 16, multiple of 4.
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- HANDLER_PC, 32'h0000_4180, exception entry address.
- TEXT_LO, 32'h0000_3000, lowest legal fetch address (inclusive).
- TEXT_HI, 32'h0000_6ffc, highest legal fetch address (inclusive).
- CNT_W, 16, width of the redirect performance counter.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall_F  in  1  hazard unit freezes F/D.
- npc_op  in  3  D-stage op: 0 seq, 1 branch, 2 j/jal, 3 jr/jalr; 4-7 treated as seq.
- b_jump  in  1  branch condition true (meaningful only when npc_op=1).
- imm26  in  26  D-stage instruction bits [25:0].
- rs_val  in  WIDTH  forwarded rs value for jr/jalr.
- pc_D  in  WIDTH  PC of the D-stage instruction.
- req  in  1  CP0 takes exception/interrupt this cycle.
- eret  in  1  eret retiring this cycle.
- epc  in  WIDTH  CP0 EPC.
- pc_F  out  WIDTH  current fetch PC (register).
- adel_F  out  1  pc_F misaligned or outside [TEXT_LO,TEXT_HI].
- kill_F  out  1  instruction in F must be replaced by nop on entry to D.
- redirect_cnt  out  CNT_W  count of non-sequential PC updates.

Behaviour:
- Reset (reset=0, async): pc_F=RESET_PC, state=RUN, kill_F=0, redirect_cnt=0. adel_F follows combinationally from pc_F. Reset mid-operation discards everything, including a pending KILL.
- Targets:
  - branch: pc_D+4+(sign-extended imm26[15:0]<<2).
  - j: {pc_D[WIDTH-1:28], imm26, 2'b00}.
  - jr: rs_val.
  - seq: pc_F+4.
  - All arithmetic is modulo 2^WIDTH.
- Next-PC priority, highest first:
  - req: pc_F<=HANDLER_PC.
  - eret: pc_F<=epc.
  - stall_F=1: pc_F holds.
  - npc_op=1 && b_jump: pc_F<=branch target.
  - npc_op=2: pc_F<=j target.
  - npc_op=3: pc_F<=jr target.
  - otherwise: pc_F<=pc_F+4.
- req and eret override stall_F. Simultaneous req+eret: req wins.
- Redirect semantics:
  - A redirect occurs on req, eret, or a taken D-stage control transfer while not stalled.
  - Branch/jump redirects do not kill F (delay slot executes).
- FSM:
  - RUN: on eret (and no req) -> KILL.
  - KILL: kill_F=1 for exactly one cycle. Next state is RUN, unless req (-> RUN, kill_F cleared next cycle) or eret again (stay in KILL).
  - kill_F is registered: it asserts the cycle after eret is sampled, i.e. while pc_F=epc's predecessor fetch has been replaced, and flags the wrong-path instruction already in F at the eret edge.
- adel_F: pc_F[1:0]!=0 or pc_F<TEXT_LO or pc_F>TEXT_HI. Unsigned compare. Combinational, no latency.
- Register updates and wrap:
  - redirect_cnt increments by 1 on every redirect edge and wraps at 2^CNT_W-1 -> 0.
  - A held stall cycle never increments.
  - pc_F+4 wraps silently at 2^WIDTH.

Test Plan:
- Reset then release, no stalls, npc_op=0 for 4 cycles -> pc_F 0x3000,0x3004,0x3008,0x300c,0x3010; adel_F=0; redirect_cnt=0.
- pc_D=0x3010, npc_op=1, b_jump=1, imm16=0xfffe -> next pc_F=0x300c, redirect_cnt=1. Same stimulus with b_jump=0 -> pc_F+4.
- stall_F=1 with npc_op=2 for 3 cycles -> pc_F frozen, cnt unchanged. Assert req in 2nd stall cycle -> pc_F=0x4180 next edge, cnt+1.
- eret=1, epc=0x3024 -> pc_F=0x3024, kill_F=1 for one cycle only. req+eret same cycle -> pc_F=0x4180, kill_F stays 0.
- npc_op=3, rs_val=0x3002 -> pc_F=0x3002, adel_F=1. rs_val=0x7000 -> adel_F=1. rs_val=0x6ffc -> adel_F=0.
- Preload redirect_cnt to 0xffff by 65535 taken jumps, one more jump -> 0x0000. Assert reset low mid-KILL -> pc_F=0x3000, kill_F=0 immediately.

Source files
------------

// File: rtl/f_pc_ctrl.sv
// rtl/f_pc_ctrl.sv - F-stage PC register with redirect merge, eret squash and redirect counter
module f_pc_ctrl #(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_PC   = 32'h0000_3000,
  parameter logic [WIDTH-1:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [WIDTH-1:0] TEXT_LO    = 32'h0000_3000,
  parameter logic [WIDTH-1:0] TEXT_HI    = 32'h0000_6ffc,
  parameter int               CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_F,
  input  logic [2:0]       npc_op,
  input  logic             b_jump,
  input  logic [25:0]      imm26,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] pc_D,
  input  logic             req,
  input  logic             eret,
  input  logic [WIDTH-1:0] epc,
  output logic [WIDTH-1:0] pc_F,
  output logic             adel_F,
  output logic             kill_F,
  output logic [CNT_W-1:0] redirect_cnt
);

  typedef enum logic {RUN, KILL} state_t;
  state_t state;

  logic [WIDTH+17:0] br_off_wide;
  logic [WIDTH-1:0]  br_tgt;
  logic [WIDTH-1:0]  j_tgt;
  logic [WIDTH-1:0]  seq_pc;
  logic [WIDTH-1:0]  next_pc;
  logic              redirect;

  // Sign extension is built over-wide so the slice stays legal down to WIDTH=16.
  assign br_off_wide = {{WIDTH{imm26[15]}}, imm26[15:0], 2'b00};
  assign br_tgt      = pc_D + WIDTH'(4) + br_off_wide[WIDTH-1:0];
  assign seq_pc      = pc_F + WIDTH'(4);

  generate
    if (WIDTH > 28) begin : g_j_wide
      assign j_tgt = {pc_D[WIDTH-1:28], imm26, 2'b00};
    end else begin : g_j_narrow
      logic [27:0] j_full;
      assign j_full = {imm26, 2'b00};
      assign j_tgt  = j_full[WIDTH-1:0];
    end
  endgenerate

  always_comb begin
    next_pc  = seq_pc;
    redirect = 1'b0;
    if (req) begin
      next_pc  = HANDLER_PC;
      redirect = 1'b1;
    end else if (eret) begin
      next_pc  = epc;
      redirect = 1'b1;
    end else if (stall_F) begin
      next_pc  = pc_F;
    end else begin
      case (npc_op)
        3'd1: if (b_jump) begin
          next_pc  = br_tgt;
          redirect = 1'b1;
        end
        3'd2: begin
          next_pc  = j_tgt;
          redirect = 1'b1;
        end
        3'd3: begin
          next_pc  = rs_val;
          redirect = 1'b1;
        end
        default: next_pc = seq_pc;
      endcase
    end
  end

  assign adel_F = (pc_F[1:0] != 2'b00) || (pc_F < TEXT_LO) || (pc_F > TEXT_HI);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_F         <= RESET_PC;
      state        <= RUN;
      kill_F       <= 1'b0;
      redirect_cnt <= '0;
    end else begin
      pc_F <= next_pc;
      if (redirect) redirect_cnt <= redirect_cnt + CNT_W'(1);
      // An eret squashes the wrong-path fetch sitting in F; a concurrent req cancels it.
      case (state)
        RUN: begin
          if (eret && !req) begin
            state  <= KILL;
            kill_F <= 1'b1;
          end else begin
            state  <= RUN;
            kill_F <= 1'b0;
          end
        end
        KILL: begin
          if (req) begin
            state  <= RUN;
            kill_F <= 1'b0;
          end else if (eret) begin
            state  <= KILL;
            kill_F <= 1'b1;
          end else begin
            state  <= RUN;
            kill_F <= 1'b0;
          end
        end
        default: begin
          state  <= RUN;
          kill_F <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_f_pc_ctrl.sv
// tb/tb_f_pc_ctrl.sv - directed table-driven bench for f_pc_ctrl
module tb_f_pc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_F;
  logic [2:0]  npc_op;
  logic        b_jump;
  logic [25:0] imm26;
  logic [31:0] rs_val;
  logic [31:0] pc_D;
  logic        req;
  logic        eret;
  logic [31:0] epc;
  logic [31:0] pc_F;
  logic        adel_F;
  logic        kill_F;
  logic [15:0] redirect_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  f_pc_ctrl dut (
    .clk(clk), .reset(reset), .stall_F(stall_F), .npc_op(npc_op), .b_jump(b_jump),
    .imm26(imm26), .rs_val(rs_val), .pc_D(pc_D), .req(req), .eret(eret), .epc(epc),
    .pc_F(pc_F), .adel_F(adel_F), .kill_F(kill_F), .redirect_cnt(redirect_cnt)
  );

  typedef struct {
    logic        stall;
    logic [2:0]  op;
    logic        bj;
    logic [25:0] imm;
    logic [31:0] rs;
    logic [31:0] pcd;
    logic        rq;
    logic        er;
    logic [31:0] ep;
    logic [31:0] e_pc;
    logic        e_adel;
    logic        e_kill;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic stall, logic [2:0] op, logic bj, logic [25:0] imm,
                              logic [31:0] rs, logic [31:0] pcd, logic rq, logic er,
                              logic [31:0] ep, logic [31:0] e_pc, logic e_adel,
                              logic e_kill, logic [15:0] e_cnt);
    vec_t v;
    v.stall = stall; v.op = op; v.bj = bj; v.imm = imm; v.rs = rs; v.pcd = pcd;
    v.rq = rq; v.er = er; v.ep = ep; v.e_pc = e_pc; v.e_adel = e_adel;
    v.e_kill = e_kill; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    stall_F = v.stall; npc_op = v.op; b_jump = v.bj; imm26 = v.imm; rs_val = v.rs;
    pc_D = v.pcd; req = v.rq; eret = v.er; epc = v.ep;
  endtask

  task automatic check_out(input string tag, input logic [31:0] e_pc, input logic e_adel,
                           input logic e_kill, input logic [15:0] e_cnt);
    chk({tag, ".pc_F"}, pc_F, e_pc);
    chk({tag, ".adel_F"}, {31'd0, adel_F}, {31'd0, e_adel});
    chk({tag, ".kill_F"}, {31'd0, kill_F}, {31'd0, e_kill});
    chk({tag, ".cnt"}, {16'd0, redirect_cnt}, {16'd0, e_cnt});
  endtask

  task automatic step(input vec_t v);
    drive(v);
    @(posedge clk);
    #1;
  endtask

  initial begin
    //     stall op bj imm       rs            pcd           rq er epc         exp_pc        adel kill cnt
    vt.push_back(mk(0, 0, 0, 26'h0,    32'h0,        32'h0,    0, 0, 32'h0,    32'h3004,     0, 0, 16'd0));
    vt.push_back(mk(0, 0, 0, 26'h0,    32'h0,        32'h0,    0, 0, 32'h0,    32'h3008,     0, 0, 16'd0));
    vt.push_back(mk(0, 0, 0, 26'h0,    32'h0,        32'h0,    0, 0, 32'h0,    32'h300c,     0, 0, 16'd0));
    vt.push_back(mk(0, 0, 0, 26'h0,    32'h0,        32'h0,    0, 0, 32'h0,    32'h3010,     0, 0, 16'd0));
    vt.push_back(mk(0, 1, 1, 26'hfffe, 32'h0,        32'h3010, 0, 0, 32'h0,    32'h300c,     0, 0, 16'd1));
    vt.push_back(mk(0, 1, 0, 26'hfffe, 32'h0,        32'h3010, 0, 0, 32'h0,    32'h3010,     0, 0, 16'd1));
    vt.push_back(mk(1, 2, 0, 26'hc00,  32'h0,        32'h3000, 0, 0, 32'h0,    32'h3010,     0, 0, 16'd1));
    vt.push_back(mk(1, 2, 0, 26'hc00,  32'h0,        32'h3000, 1, 0, 32'h0,    32'h4180,     0, 0, 16'd2));
    vt.push_back(mk(1, 2, 0, 26'hc00,  32'h0,        32'h3000, 0, 0, 32'h0,    32'h4180,     0, 0, 16'd2));
    vt.push_back(mk(0, 0, 0, 26'h0,    32'h0,        32'h0,    0, 1, 32'h3024, 32'h3024,     0, 1, 16'd3));
    vt.push_back(mk(0, 0, 0, 26'h0,    32'h0,        32'h0,    0, 0, 32'h0,    32'h3028,     0, 0, 16'd3));
    vt.push_back(mk(0, 0, 0, 26'h0,    32'h0,        32'h0,    1, 1, 32'h3024, 32'h4180,     0, 0, 16'd4));
    vt.push_back(mk(0, 3, 0, 26'h0,    32'h3002,     32'h0,    0, 0, 32'h0,    32'h3002,     1, 0, 16'd5));
    vt.push_back(mk(0, 3, 0, 26'h0,    32'h7000,     32'h0,    0, 0, 32'h0,    32'h7000,     1, 0, 16'd6));
    vt.push_back(mk(0, 3, 0, 26'h0,    32'h6ffc,     32'h0,    0, 0, 32'h0,    32'h6ffc,     0, 0, 16'd7));
    vt.push_back(mk(0, 0, 0, 26'h0,    32'h0,        32'h0,    0, 0, 32'h0,    32'h7000,     1, 0, 16'd7));
    vt.push_back(mk(0, 2, 0, 26'hc04,  32'h0,        32'h3000, 0, 0, 32'h0,    32'h3010,     0, 0, 16'd8));
    vt.push_back(mk(0, 0, 0, 26'h0,    32'h0,        32'h0,    0, 1, 32'h3040, 32'h3040,     0, 1, 16'd9));
    vt.push_back(mk(0, 0, 0, 26'h0,    32'h0,        32'h0,    0, 1, 32'h3050, 32'h3050,     0, 1, 16'd10));
    vt.push_back(mk(1, 0, 0, 26'h0,    32'h0,        32'h0,    0, 1, 32'h3060, 32'h3060,     0, 1, 16'd11));
    vt.push_back(mk(0, 0, 0, 26'h0,    32'h0,        32'h0,    1, 0, 32'h0,    32'h4180,     0, 0, 16'd12));
    vt.push_back(mk(1, 1, 1, 26'h4,    32'h0,        32'h3000, 0, 0, 32'h0,    32'h4180,     0, 0, 16'd12));
    vt.push_back(mk(0, 5, 1, 26'h4,    32'h0,        32'h3000, 0, 0, 32'h0,    32'h4184,     0, 0, 16'd12));
    vt.push_back(mk(0, 1, 1, 26'h4,    32'h0,        32'h3000, 0, 0, 32'h0,    32'h3014,     0, 0, 16'd13));
    vt.push_back(mk(0, 3, 0, 26'h0,    32'hfffffffc, 32'h0,    0, 0, 32'h0,    32'hfffffffc, 1, 0, 16'd14));
    vt.push_back(mk(0, 0, 0, 26'h0,    32'h0,        32'h0,    0, 0, 32'h0,    32'h0,        1, 0, 16'd14));

    reset = 1'b0;
    drive(mk(0, 0, 0, 26'h0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 16'd0));
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 32'h3000, 1'b0, 1'b0, 16'd0);
    reset = 1'b1;

    for (int i = 0; i < vt.size(); i++) begin
      step(vt[i]);
      check_out($sformatf("vec%0d", i), vt[i].e_pc, vt[i].e_adel, vt[i].e_kill, vt[i].e_cnt);
    end

    // Drive the counter up to its top value with taken jumps, then wrap it.
    for (int i = 0; i < 65535 - 14; i++)
      step(mk(0, 2, 0, 26'hc04, 32'h0, 32'h3000, 0, 0, 32'h0, 32'h0, 0, 0, 16'd0));
    check_out("cnt_top", 32'h3010, 1'b0, 1'b0, 16'hffff);
    step(mk(0, 2, 0, 26'hc08, 32'h0, 32'h3000, 0, 0, 32'h0, 32'h0, 0, 0, 16'd0));
    check_out("cnt_wrap", 32'h3020, 1'b0, 1'b0, 16'h0000);

    // Asynchronous reset while in KILL.
    step(mk(0, 0, 0, 26'h0, 32'h0, 32'h0, 0, 1, 32'h3024, 32'h0, 0, 0, 16'd0));
    check_out("kill_pre", 32'h3024, 1'b0, 1'b1, 16'd1);
    drive(mk(0, 0, 0, 26'h0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 16'd0));
    #1 reset = 1'b0;
    #1;
    check_out("async_rst", 32'h3000, 1'b0, 1'b0, 16'd0);
    @(negedge clk);
    reset = 1'b1;
    step(mk(0, 0, 0, 26'h0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 16'd0));
    check_out("post_rst", 32'h3004, 1'b0, 1'b0, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
